seq_divider: RTL and testbench



---
 rtl/seq_divider_pkg.sv | 22 ++
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider_div_step.sv | 26 ++
 rtl/seq_divider.sv | 106 ++++++++++
 tb/tb_seq_divider.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_divider_pkg;

    // IDLE waits for start; RUN produces one quotient bit per clock.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 32;

    // Iteration counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

    // Quotient returned for divide-by-zero and overflow (all ones at the default width).
    localparam logic [DEF_WIDTH-1:0] EXC_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   busy;
    logic                   done;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   div_by_zero;
    logic                   overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {r[WIDTH-1:0], next_bit};
    assign diff    = shifted - {1'b0, divisor};

    // r stays below divisor, so the shifted value fits in WIDTH+1 bits.
    always_comb begin
        q_bit  = 1'b0;
        r_next = shifted;
        if (shifted >= {1'b0, divisor}) begin
            q_bit  = 1'b1;
            r_next = diff;
        end
    end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | waiting for start; exceptions resolve here in one clock
//  RUN   | one quotient bit per clock, down-counter from WIDTH to 0
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     r_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   div_reg;
    logic               busy_q, done_q, dbz_q, ovf_q;
    logic [WIDTH-1:0]   quot_q, rem_q;

    logic [WIDTH:0]     r_next;
    logic               q_bit;
    logic [WIDTH-1:0]   dvd_hi, dvd_lo;

    assign dvd_hi = bus.dividend[2*WIDTH-1:WIDTH];
    assign dvd_lo = bus.dividend[WIDTH-1:0];

    div_step #(.WIDTH(WIDTH)) u_step (
        .r        (r_reg),
        .next_bit (q_reg[WIDTH-1]),
        .divisor  (div_reg),
        .r_next   (r_next),
        .q_bit    (q_bit)
    );

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            r_reg   <= '0;
            q_reg   <= '0;
            div_reg <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        dbz_q <= 1'b0;
                        ovf_q <= 1'b0;
                        if (bus.divisor == '0) begin
                            done_q <= 1'b1;
                            dbz_q  <= 1'b1;
                            quot_q <= '1;
                            rem_q  <= dvd_lo;
                        end else if (dvd_hi >= bus.divisor) begin
                            // Quotient needs more than WIDTH bits.
                            done_q <= 1'b1;
                            ovf_q  <= 1'b1;
                            quot_q <= '1;
                            rem_q  <= '0;
                        end else begin
                            r_reg   <= {1'b0, dvd_hi};
                            q_reg   <= dvd_lo;
                            div_reg <= bus.divisor;
                            cnt     <= CW'(WIDTH);
                            busy_q  <= 1'b1;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_reg <= r_next;
                    q_reg <= {q_reg[WIDTH-2:0], q_bit};
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quot_q <= {q_reg[WIDTH-2:0], q_bit};
                        rem_q  <= r_next[WIDTH-1:0];
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against a plain-arithmetic reference.
module tb_seq_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: what a divide of dvd by dvs must report.
    function automatic void model_div(input logic [63:0] dvd, input logic [31:0] dvs,
                                      output logic [31:0] q, output logic [31:0] r,
                                      output logic dbz, output logic ovf, output int lat);
        logic [63:0] qq;
        dbz = 1'b0; ovf = 1'b0; lat = W;
        if (dvs == 0) begin
            dbz = 1'b1; q = 32'hFFFF_FFFF; r = dvd[31:0]; lat = 0;
        end else begin
            qq = dvd / {32'd0, dvs};
            if (qq > 64'h0000_0000_FFFF_FFFF) begin
                ovf = 1'b1; q = 32'hFFFF_FFFF; r = 32'd0; lat = 0;
            end else begin
                q = qq[31:0];
                r = 32'(dvd % {32'd0, dvs});
            end
        end
    endfunction

    // Issue one division, scramble inputs afterwards, wait (bounded) for done.
    task automatic run_div(input logic [63:0] dvd, input logic [31:0] dvs,
                           output int lat, output int busy_cycles);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = dvd; bus.divisor = dvs;
        @(negedge clk);
        bus.start = 1'b0;
        bus.dividend = {$urandom, $urandom};
        bus.divisor = $urandom;
        lat = 0; busy_cycles = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_op(input string name, input logic [63:0] dvd, input logic [31:0] dvs);
        int lat, bc, elat;
        logic [31:0] eq, er;
        logic edbz, eovf;
        model_div(dvd, dvs, eq, er, edbz, eovf, elat);
        run_div(dvd, dvs, lat, bc);
        checks++;
        if (lat !== elat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, elat); end
        checks++;
        if (bc !== elat) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, bc, elat); end
        checks++;
        if (bus.quotient !== eq) begin failures++; $display("FAIL %s quotient got=%h exp=%h", name, bus.quotient, eq); end
        checks++;
        if (bus.remainder !== er) begin failures++; $display("FAIL %s remainder got=%h exp=%h", name, bus.remainder, er); end
        checks++;
        if (bus.div_by_zero !== edbz) begin failures++; $display("FAIL %s div_by_zero got=%b exp=%b", name, bus.div_by_zero, edbz); end
        checks++;
        if (bus.overflow !== eovf) begin failures++; $display("FAIL %s overflow got=%b exp=%b", name, bus.overflow, eovf); end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== '0) begin
            failures++;
            $display("FAIL reset outputs got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b exp all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        check_op("basic_100_7", 64'd100, 32'd7);
        checks++;
        if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
            failures++; $display("FAIL basic_const got=%0d r%0d exp=14 r2", bus.quotient, bus.remainder);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", bus.done); end
        check_op("product_check", 64'd14924014882973888, 32'd121212121);
        checks++;
        if (bus.quotient !== 32'd123123123 || bus.remainder !== 32'd5) begin
            failures++; $display("FAIL product_const got=%0d r%0d exp=123123123 r5", bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_exceptions();
        check_op("div_zero", 64'd5, 32'd0);
        checks++;
        if (bus.div_by_zero !== 1'b1 || bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 32'd5) begin
            failures++; $display("FAIL div_zero_const got dbz=%b q=%h r=%h", bus.div_by_zero, bus.quotient, bus.remainder);
        end
        check_op("overflow_edge", 64'h1_0000_0000, 32'd1);
        checks++;
        if (bus.overflow !== 1'b1 || bus.div_by_zero !== 1'b0) begin
            failures++; $display("FAIL overflow_flags got ovf=%b dbz=%b exp ovf=1 dbz=0", bus.overflow, bus.div_by_zero);
        end
        check_op("max_fit", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
        checks++;
        if (bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 32'd0 || bus.overflow !== 1'b0) begin
            failures++; $display("FAIL max_fit_const got q=%h r=%h ovf=%b", bus.quotient, bus.remainder, bus.overflow);
        end
    endtask

    task automatic test_mid_reset();
        int seen;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 64'd100; bus.divisor = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== '0) begin
            failures++;
            $display("FAIL mid_reset outputs got busy=%b done=%b q=%h r=%h exp all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL mid_reset_no_done got=%0d exp=0", seen); end
        check_op("after_reset_9_3", 64'd9, 32'd3);
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 64'd100; bus.divisor = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (lat == 4) begin bus.start = 1'b1; bus.dividend = 64'd50; bus.divisor = 32'd5; end
            else bus.start = 1'b0;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== W) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, W); end
        checks++;
        if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
            failures++; $display("FAIL b2b_first got=%0d r%0d exp=14 r2", bus.quotient, bus.remainder);
        end
        bus.start = 1'b1; bus.dividend = 64'd50; bus.divisor = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept busy got=%b exp=1", bus.busy); end
        lat = 0;
        while (bus.done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== W) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, W); end
        checks++;
        if (bus.quotient !== 32'd10 || bus.remainder !== 32'd0) begin
            failures++; $display("FAIL b2b_second got=%0d r%0d exp=10 r0", bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, rr;
        logic [63:0] dvd;
        for (int i = 0; i < 24; i++) begin
            a = $urandom; b = $urandom; rr = $urandom;
            case ($urandom_range(0, 4))
                0: begin dvd = {a, b}; b = 32'd0; end
                1: begin b = b >> $urandom_range(0, 31); dvd = {b | a, rr}; end
                2: begin b = b >> $urandom_range(0, 31); if (b == 0) b = 1;
                         dvd = {32'd0, a} * {32'd0, b} + {32'd0, rr % b}; end
                default: begin if (b == 0) b = 1; dvd = {$urandom, $urandom} % {b, 32'd0}; end
            endcase
            check_op($sformatf("random_%0d", i), dvd, b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exceptions();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
